// File: rtl/alu_core.sv
// Registered 32-bit data-processing ALU with barrel shifter.
// Produces the Rd result and the next N/Z/C/V flags one edge after each execute strobe.
module alu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        cu_execute,
  input  logic [3:0]  instruction,
  input  logic [31:0] Rn,
  input  logic [31:0] Rm,
  input  logic [7:0]  Rs,
  input  logic [4:0]  imm_shift,
  input  logic [11:0] imm_OP_2,
  input  logic        I,
  input  logic        S,
  input  logic [1:0]  stype,
  input  logic        n,
  input  logic        z,
  input  logic        c,
  input  logic        v,
  output logic        w_n,
  output logic        w_z,
  output logic        w_c,
  output logic        w_v,
  output logic [31:0] w_Rd
);

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  localparam logic [1:0] SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3;

  logic [31:0] w_rd_q, w_rd_d;
  logic [3:0]  flags_q, flags_d;

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
    logic [5:0] lsh;
    lsh = 6'd32 - {1'b0, r};
    return (x >> r) | (x << lsh);
  endfunction

  logic [7:0]  amt;
  logic [32:0] lsl_t, lsr_t;
  logic [31:0] asr_t, ror_t, imm_t;
  logic [31:0] op2;
  logic        sc;

  assign amt   = (Rs != 8'd0) ? Rs : {3'b000, imm_shift};
  assign lsl_t = {1'b0, Rm} << amt[4:0];
  assign lsr_t = {Rm, 1'b0} >> amt[4:0];
  assign asr_t = $signed(Rm) >>> amt[4:0];
  assign ror_t = ror32(Rm, amt[4:0]);
  assign imm_t = ror32({24'b0, imm_OP_2[7:0]}, {imm_OP_2[11:8], 1'b0});

  // lsl_t[32] / lsr_t[0] hold the last bit shifted out for in-range amounts.
  always_comb begin
    op2 = Rm;
    sc  = c;
    if (I) begin
      op2 = imm_t;
      sc  = (imm_OP_2[11:8] == 4'd0) ? c : imm_t[31];
    end else if (amt != 8'd0) begin
      unique case (stype)
        SH_LSL: begin
          if (amt < 8'd32) begin
            op2 = lsl_t[31:0];
            sc  = lsl_t[32];
          end else begin
            op2 = 32'd0;
            sc  = (amt == 8'd32) ? Rm[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (amt < 8'd32) begin
            op2 = lsr_t[32:1];
            sc  = lsr_t[0];
          end else begin
            op2 = 32'd0;
            sc  = (amt == 8'd32) ? Rm[31] : 1'b0;
          end
        end
        SH_ASR: begin
          if (amt < 8'd32) begin
            op2 = asr_t;
            sc  = lsr_t[0];
          end else begin
            op2 = {32{Rm[31]}};
            sc  = Rm[31];
          end
        end
        default: begin
          op2 = ror_t;
          sc  = ror_t[31];
        end
      endcase
    end
  end

  logic [31:0] add_a, add_b, result;
  logic        add_cin, is_arith;
  logic [32:0] sum;

  always_comb begin
    add_a    = Rn;
    add_b    = op2;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    unique case (instruction)
      OP_SUB, OP_CMP: begin add_b = ~op2; add_cin = 1'b1; end
      OP_RSB:         begin add_a = op2; add_b = ~Rn; add_cin = 1'b1; end
      OP_ADD, OP_CMN: add_cin = 1'b0;
      OP_ADC:         add_cin = c;
      OP_SBC:         begin add_b = ~op2; add_cin = c; end
      OP_RSC:         begin add_a = op2; add_b = ~Rn; add_cin = c; end
      default:        is_arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  always_comb begin
    result = sum[31:0];
    unique case (instruction)
      OP_AND, OP_TST: result = Rn & op2;
      OP_EOR, OP_TEQ: result = Rn ^ op2;
      OP_ORR:         result = Rn | op2;
      OP_BIC:         result = Rn & ~op2;
      OP_MOV:         result = op2;
      OP_MVN:         result = ~op2;
      default:        result = sum[31:0];
    endcase
  end

  // Opcodes 8..B are compare/test: they always set flags and never write Rd.
  logic is_cmp, upd, ovf;
  assign is_cmp = (instruction[3:2] == 2'b10);
  assign upd    = S | is_cmp;
  assign ovf    = (add_a[31] == add_b[31]) && (sum[31] != add_a[31]);

  always_comb begin
    w_rd_d  = w_rd_q;
    flags_d = flags_q;
    if (cu_execute) begin
      if (!is_cmp)
        w_rd_d = result;
      if (!upd)
        flags_d = {n, z, c, v};
      else if (is_arith)
        flags_d = {result[31], result == 32'd0, sum[32], ovf};
      else
        flags_d = {result[31], result == 32'd0, sc, v};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_rd_q  <= 32'd0;
      flags_q <= 4'd0;
    end else begin
      w_rd_q  <= w_rd_d;
      flags_q <= flags_d;
    end
  end

  assign w_Rd = w_rd_q;
  assign {w_n, w_z, w_c, w_v} = flags_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: reset, shifter, immediates, arithmetic flags, hold, async reset.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cu_execute = 1'b0;
  logic [3:0]  instruction = 4'h0;
  logic [31:0] Rn = 32'd0, Rm = 32'd0;
  logic [7:0]  Rs = 8'd0;
  logic [4:0]  imm_shift = 5'd0;
  logic [11:0] imm_OP_2 = 12'd0;
  logic        I = 1'b0, S = 1'b0;
  logic [1:0]  stype = 2'd0;
  logic        n = 1'b0, z = 1'b0, c = 1'b0, v = 1'b0;
  logic        w_n, w_z, w_c, w_v;
  logic [31:0] w_Rd;

  int n_assert = 0;
  int n_fail   = 0;

  alu_core dut (
    .clk(clk), .rst(rst), .cu_execute(cu_execute), .instruction(instruction),
    .Rn(Rn), .Rm(Rm), .Rs(Rs), .imm_shift(imm_shift), .imm_OP_2(imm_OP_2),
    .I(I), .S(S), .stype(stype), .n(n), .z(z), .c(c), .v(v),
    .w_n(w_n), .w_z(w_z), .w_c(w_c), .w_v(w_v), .w_Rd(w_Rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got_rd, input logic [3:0] got_f,
                     input logic [31:0] exp_rd, input logic [3:0] exp_f);
    n_assert++;
    assert (got_rd === exp_rd) else begin
      n_fail++;
      $error("FAIL %s Rd: observed %h expected %h", tag, got_rd, exp_rd);
    end
    n_assert++;
    assert (got_f === exp_f) else begin
      n_fail++;
      $error("FAIL %s NZCV: observed %b expected %b", tag, got_f, exp_f);
    end
    $display("%s: Rd=%h NZCV=%b (expected %h %b)", tag, got_rd, got_f, exp_rd, exp_f);
  endtask

  // Drive one execute edge; operands set after a falling edge, outputs sampled 1 ns after rising edge.
  task automatic exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] m,
                      input logic [7:0] rs_v, input logic [4:0] ish, input logic [11:0] imm,
                      input logic i_v, input logic s_v, input logic [1:0] st, input logic [3:0] nzcv);
    @(negedge clk);
    instruction = op; Rn = a; Rm = m; Rs = rs_v; imm_shift = ish; imm_OP_2 = imm;
    I = i_v; S = s_v; stype = st; {n, z, c, v} = nzcv;
    cu_execute = 1'b1;
    @(posedge clk);
    #1;
    cu_execute = 1'b0;
  endtask

  initial begin
    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("reset_idle", w_Rd, {w_n, w_z, w_c, w_v}, 32'd0, 4'b0000);
    end

    // ADD with signed overflow
    exec(4'h4, 32'h7FFF_FFFF, 32'd0, 8'd0, 5'd0, 12'h001, 1, 1, 2'd0, 4'b0000);
    chk("add_ovf", w_Rd, {w_n, w_z, w_c, w_v}, 32'h8000_0000, 4'b1001);

    // CMP equal, S=0: flags still update, Rd kept
    exec(4'hA, 32'd5, 32'd5, 8'd0, 5'd0, 12'h000, 0, 0, 2'd0, 4'b0000);
    chk("cmp_eq", w_Rd, {w_n, w_z, w_c, w_v}, 32'h8000_0000, 4'b0110);

    // Shifter
    exec(4'hD, 32'd0, 32'h8000_0001, 8'd0, 5'd1, 12'h000, 0, 1, 2'd0, 4'b0001);
    chk("lsl1", w_Rd, {w_n, w_z, w_c, w_v}, 32'h0000_0002, 4'b0011);
    exec(4'hD, 32'd0, 32'h8000_0001, 8'd40, 5'd0, 12'h000, 0, 1, 2'd2, 4'b0000);
    chk("asr40", w_Rd, {w_n, w_z, w_c, w_v}, 32'hFFFF_FFFF, 4'b1010);
    exec(4'hD, 32'd0, 32'h8000_0001, 8'd0, 5'd4, 12'h000, 0, 1, 2'd3, 4'b0010);
    chk("ror4", w_Rd, {w_n, w_z, w_c, w_v}, 32'h1800_0000, 4'b0000);
    exec(4'hD, 32'd0, 32'h8000_0001, 8'd32, 5'd0, 12'h000, 0, 1, 2'd0, 4'b0000);
    chk("lsl32", w_Rd, {w_n, w_z, w_c, w_v}, 32'd0, 4'b0110);
    exec(4'hD, 32'd0, 32'hFFFF_FFFF, 8'd33, 5'd0, 12'h000, 0, 1, 2'd0, 4'b0010);
    chk("lsl33", w_Rd, {w_n, w_z, w_c, w_v}, 32'd0, 4'b0100);
    exec(4'hD, 32'd0, 32'h7FFF_FFFF, 8'd32, 5'd0, 12'h000, 0, 1, 2'd1, 4'b0010);
    chk("lsr32", w_Rd, {w_n, w_z, w_c, w_v}, 32'd0, 4'b0100);
    exec(4'hD, 32'd0, 32'h0000_000F, 8'd0, 5'd4, 12'h000, 0, 1, 2'd1, 4'b0000);
    chk("lsr4", w_Rd, {w_n, w_z, w_c, w_v}, 32'd0, 4'b0110);
    exec(4'hD, 32'd0, 32'h1234_5678, 8'd0, 5'd0, 12'h000, 0, 1, 2'd3, 4'b0010);
    chk("amt0", w_Rd, {w_n, w_z, w_c, w_v}, 32'h1234_5678, 4'b0010);
    exec(4'hD, 32'd0, 32'h8000_0000, 8'd32, 5'd0, 12'h000, 0, 1, 2'd3, 4'b0000);
    chk("ror32", w_Rd, {w_n, w_z, w_c, w_v}, 32'h8000_0000, 4'b1010);

    // Rotated immediates
    exec(4'hD, 32'd0, 32'd0, 8'd0, 5'd0, 12'hF0F, 1, 1, 2'd0, 4'b0010);
    chk("imm_rot30", w_Rd, {w_n, w_z, w_c, w_v}, 32'h0000_003C, 4'b0000);
    exec(4'hD, 32'd0, 32'd0, 8'd0, 5'd0, 12'h4FF, 1, 1, 2'd0, 4'b0000);
    chk("imm_rot8", w_Rd, {w_n, w_z, w_c, w_v}, 32'hFF00_0000, 4'b1010);

    // Carry-in arithmetic
    exec(4'h5, 32'hFFFF_FFFF, 32'd0, 8'd0, 5'd0, 12'h001, 1, 1, 2'd0, 4'b0010);
    chk("adc", w_Rd, {w_n, w_z, w_c, w_v}, 32'h0000_0001, 4'b0010);
    exec(4'h6, 32'd10, 32'd0, 8'd0, 5'd0, 12'h003, 1, 1, 2'd0, 4'b0000);
    chk("sbc", w_Rd, {w_n, w_z, w_c, w_v}, 32'h0000_0006, 4'b0010);
    exec(4'h3, 32'd1, 32'd0, 8'd0, 5'd0, 12'h000, 1, 1, 2'd0, 4'b0000);
    chk("rsb", w_Rd, {w_n, w_z, w_c, w_v}, 32'hFFFF_FFFF, 4'b1000);
    exec(4'h7, 32'd1, 32'd0, 8'd0, 5'd0, 12'h102, 1, 1, 2'd0, 4'b0010);
    chk("rsc_ovf", w_Rd, {w_n, w_z, w_c, w_v}, 32'h7FFF_FFFF, 4'b0011);

    // Logical ops
    exec(4'h0, 32'h0000_00F0, 32'd0, 8'd0, 5'd0, 12'h0FF, 1, 0, 2'd0, 4'b0101);
    chk("and_noS", w_Rd, {w_n, w_z, w_c, w_v}, 32'h0000_00F0, 4'b0101);
    exec(4'h1, 32'h0000_00FF, 32'd0, 8'd0, 5'd0, 12'h0FF, 1, 1, 2'd0, 4'b0011);
    chk("eor", w_Rd, {w_n, w_z, w_c, w_v}, 32'd0, 4'b0111);
    exec(4'hC, 32'h0000_0F00, 32'd0, 8'd0, 5'd0, 12'h00F, 1, 0, 2'd0, 4'b0000);
    chk("orr", w_Rd, {w_n, w_z, w_c, w_v}, 32'h0000_0F0F, 4'b0000);
    exec(4'hE, 32'h0000_00FF, 32'd0, 8'd0, 5'd0, 12'h00F, 1, 0, 2'd0, 4'b0000);
    chk("bic", w_Rd, {w_n, w_z, w_c, w_v}, 32'h0000_00F0, 4'b0000);
    exec(4'hF, 32'd0, 32'd0, 8'd0, 5'd0, 12'h000, 1, 1, 2'd0, 4'b0000);
    chk("mvn", w_Rd, {w_n, w_z, w_c, w_v}, 32'hFFFF_FFFF, 4'b1000);

    // Test/compare leave Rd alone
    exec(4'h8, 32'd1, 32'd0, 8'd0, 5'd0, 12'h002, 1, 0, 2'd0, 4'b0001);
    chk("tst", w_Rd, {w_n, w_z, w_c, w_v}, 32'hFFFF_FFFF, 4'b0101);
    exec(4'h9, 32'h8000_0000, 32'd0, 8'd0, 5'd0, 12'h001, 1, 0, 2'd0, 4'b0000);
    chk("teq", w_Rd, {w_n, w_z, w_c, w_v}, 32'hFFFF_FFFF, 4'b1000);
    exec(4'hB, 32'hFFFF_FFFF, 32'd0, 8'd0, 5'd0, 12'h001, 1, 0, 2'd0, 4'b0000);
    chk("cmn", w_Rd, {w_n, w_z, w_c, w_v}, 32'hFFFF_FFFF, 4'b0110);

    // SUB, then hold with toggling inputs
    exec(4'h2, 32'd3, 32'd0, 8'd0, 5'd0, 12'h005, 1, 1, 2'd0, 4'b0000);
    chk("sub", w_Rd, {w_n, w_z, w_c, w_v}, 32'hFFFF_FFFE, 4'b1000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      instruction = 4'(k + 4); Rn = $urandom; Rm = $urandom; imm_OP_2 = 12'h0FF;
      S = 1'b1; {n, z, c, v} = 4'b1111;
      @(posedge clk); #1;
      chk("hold", w_Rd, {w_n, w_z, w_c, w_v}, 32'hFFFF_FFFE, 4'b1000);
    end

    // Async reset between edges, held across an execute edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", w_Rd, {w_n, w_z, w_c, w_v}, 32'd0, 4'b0000);
    instruction = 4'hD; I = 1'b1; imm_OP_2 = 12'h0AB; S = 1'b1; cu_execute = 1'b1;
    @(posedge clk); #1;
    chk("rst_held", w_Rd, {w_n, w_z, w_c, w_v}, 32'd0, 4'b0000);
    @(negedge clk);
    rst = 1'b0; cu_execute = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_idle", w_Rd, {w_n, w_z, w_c, w_v}, 32'd0, 4'b0000);
    exec(4'hD, 32'd0, 32'd0, 8'd0, 5'd0, 12'h0AB, 1, 1, 2'd0, 4'b0000);
    chk("first_exec", w_Rd, {w_n, w_z, w_c, w_v}, 32'h0000_00AB, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
